pipe_hazard_ctrl: RTL and testbench

//   Parametrised stall/nop controller for the 5-stage pipeline (IF,ID,EX,MEM,WB).

---
 rtl/pipe_pkg.sv | 32 +++
 rtl/store_hold_fsm.sv | 67 ++++++
 rtl/pipe_hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: stage indices,
// MEM-op bit positions, store-hold FSM states and per-stage stall/nop masks.
package pipe_pkg;

    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;
    localparam int NSTG    = 5;

    localparam int MEMRW_RD = 1;
    localparam int MEMRW_WR = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_DONE = 2'd2
    } hold_state_t;

    function automatic logic [NSTG-1:0] stg_bit(input int stg);
        logic [NSTG-1:0] one;
        one = 5'd1;
        return one << stg;
    endfunction

    localparam logic [NSTG-1:0] STALL_RAW = stg_bit(STG_IF) | stg_bit(STG_ID);
    localparam logic [NSTG-1:0] STALL_ALL = STALL_RAW | stg_bit(STG_EX) | stg_bit(STG_MEM) | stg_bit(STG_WB);
    localparam logic [NSTG-1:0] NOP_RAW   = stg_bit(STG_EX);
    localparam logic [NSTG-1:0] NOP_FLUSH = stg_bit(STG_ID) | stg_bit(STG_EX);

endpackage

// File: rtl/store_hold_fsm.sv
// Holds the MEM stage for STORE_HOLD cycles per store, then waits for the
// store to actually leave MEM before it can recognise the next one.
module store_hold_fsm
    import pipe_pkg::*;
#(
    parameter int STORE_HOLD = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_mem_wr,
    input  logic i_mem_stall_ext,
    output logic o_hold
);

    localparam int HW = (STORE_HOLD > 2) ? $clog2(STORE_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_INIT = HW'((STORE_HOLD > 1) ? (STORE_HOLD - 1) : 0);
    localparam logic HOLD_EN = (STORE_HOLD > 0);
    localparam logic MULTI   = (STORE_HOLD > 1);

    hold_state_t   r_state;
    logic [HW-1:0] r_cnt;
    logic [HW-1:0] w_cnt_dec;

    assign w_cnt_dec = r_cnt - HW'(1);

    // State/count update; the IDLE cycle that sees the store is the first held cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_mem_wr && HOLD_EN) begin
                        r_cnt <= HOLD_INIT;
                        if (MULTI) begin
                            r_state <= S_HOLD;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_HOLD: begin
                    r_cnt <= w_cnt_dec;
                    if (w_cnt_dec == '0) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!i_mem_stall_ext) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Hold is visible in the same cycle the store reaches MEM.
    always_comb begin
        o_hold = ((r_state == S_IDLE) && i_mem_wr && HOLD_EN) || (r_state == S_HOLD);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/nop controller for the 5-stage pipeline: RAW detection, memory-wait and
// store-hold stalls, deferred branch flushes and saturating perf counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int NWR        = 3,
    parameter int REG_AW     = 5,
    parameter int FWD_EN     = 0,
    parameter int STORE_HOLD = 2,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_AW-1:0]     id_rs1,
    input  logic [REG_AW-1:0]     id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [NWR*REG_AW-1:0] wr_reg,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR-1:0]        wr_is_load,
    input  logic                  branch_taken,
    input  logic                  iready_n,
    input  logic                  dready_n,
    input  logic                  dbusy,
    input  logic [1:0]            mem_rw,
    output logic [NSTG-1:0]       stall,
    output logic [NSTG-1:0]       nop,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    logic [NWR-1:0]   w_match;
    logic             w_raw;
    logic             w_raw_eff;
    logic             w_hold;
    logic             w_mem_stall_ext;
    logic             w_mem_stall;
    logic             w_flush;
    logic             w_flush_apply;
    logic [NSTG-1:0]  w_stall;
    logic [NSTG-1:0]  w_nop;
    logic             w_unused;
    logic             r_flush_pend;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // x0 is hard-wired zero, so a writer targeting it never creates a hazard.
    for (genvar k = 0; k < NWR; k++) begin : g_match
        logic [REG_AW-1:0] w_slot;
        assign w_slot     = wr_reg[k*REG_AW +: REG_AW];
        assign w_match[k] = wr_en[k] && (w_slot != '0) &&
                            ((id_rs1_used && (id_rs1 == w_slot)) ||
                             (id_rs2_used && (id_rs2 == w_slot)));
    end

    assign w_unused = ^wr_is_load;

    // With forwarding only a load in EX cannot be bypassed in time.
    always_comb begin
        if (FWD_EN != 0) begin
            w_raw = w_match[0] && wr_is_load[0];
        end else begin
            w_raw = |w_match;
        end
    end

    assign w_mem_stall_ext = iready_n || (dready_n && mem_rw[MEMRW_RD]) || dbusy;
    assign w_mem_stall     = w_mem_stall_ext || w_hold;
    assign w_flush         = branch_taken || r_flush_pend;
    assign w_flush_apply   = w_flush && !w_mem_stall;
    assign w_raw_eff       = w_raw && !w_flush;

    store_hold_fsm #(
        .STORE_HOLD (STORE_HOLD)
    ) u_store_hold (
        .clk             (clk),
        .rst             (rst),
        .i_mem_wr        (mem_rw[MEMRW_WR]),
        .i_mem_stall_ext (w_mem_stall_ext),
        .o_hold          (w_hold)
    );

    // Priority: memory stall, then flush, then RAW bubble.
    always_comb begin
        w_stall = 5'b00000;
        w_nop   = 5'b00000;
        if (!rst) begin
            w_stall = 5'b00000;
            w_nop   = 5'b00000;
        end else if (w_mem_stall) begin
            w_stall = STALL_ALL;
        end else if (w_flush) begin
            w_nop   = NOP_FLUSH;
        end else if (w_raw_eff) begin
            w_stall = STALL_RAW;
            w_nop   = NOP_RAW;
        end else begin
            w_stall = 5'b00000;
            w_nop   = 5'b00000;
        end
    end

    // Pending-flush latch and saturating performance counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_flush_pend <= 1'b0;
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
        end else begin
            r_flush_pend <= w_mem_stall && w_flush;
            if (w_stall[STG_IF] && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (w_flush_apply && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign stall     = w_stall;
    assign nop       = w_nop;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: two controllers (no forwarding / forwarding with 4-bit
// counters) share stimulus; expected outputs are queued per cycle and checked.
module tb_pipe_hazard_ctrl;

    localparam logic [4:0] ALL = 5'b11111;
    localparam logic [4:0] RS  = 5'b00011;
    localparam logic [4:0] RN  = 5'b00100;
    localparam logic [4:0] FN  = 5'b00110;
    localparam logic [4:0] Z   = 5'b00000;

    typedef struct {
        string       tag;
        logic [4:0]  s0, n0, s1, n1;
        logic [31:0] sc0, fc0;
        logic [3:0]  sc1, fc1;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2;
    logic        id_rs1_used, id_rs2_used;
    logic [14:0] wr_reg;
    logic [2:0]  wr_en, wr_is_load;
    logic        branch_taken, iready_n, dready_n, dbusy;
    logic [1:0]  mem_rw;
    logic [4:0]  stall0, nop0, stall1, nop1;
    logic [31:0] scnt0, fcnt0;
    logic [3:0]  scnt1, fcnt1;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_sc0 = 32'd0;
    logic [31:0] m_fc0 = 32'd0;
    logic [3:0]  m_sc1 = 4'd0;
    logic [3:0]  m_fc1 = 4'd0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.NWR(3), .REG_AW(5), .FWD_EN(0), .STORE_HOLD(2), .CNT_W(32)) dut0 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .wr_reg(wr_reg), .wr_en(wr_en), .wr_is_load(wr_is_load),
        .branch_taken(branch_taken), .iready_n(iready_n), .dready_n(dready_n),
        .dbusy(dbusy), .mem_rw(mem_rw), .stall(stall0), .nop(nop0),
        .stall_cnt(scnt0), .flush_cnt(fcnt0));

    pipe_hazard_ctrl #(.NWR(3), .REG_AW(5), .FWD_EN(1), .STORE_HOLD(2), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .wr_reg(wr_reg), .wr_en(wr_en), .wr_is_load(wr_is_load),
        .branch_taken(branch_taken), .iready_n(iready_n), .dready_n(dready_n),
        .dbusy(dbusy), .mem_rw(mem_rw), .stall(stall1), .nop(nop1),
        .stall_cnt(scnt1), .flush_cnt(fcnt1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pop one expectation per cycle and compare both controllers mid-cycle.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk({mon_e.tag, "/stall0"}, 32'(stall0), 32'(mon_e.s0));
            chk({mon_e.tag, "/nop0"},   32'(nop0),   32'(mon_e.n0));
            chk({mon_e.tag, "/stall1"}, 32'(stall1), 32'(mon_e.s1));
            chk({mon_e.tag, "/nop1"},   32'(nop1),   32'(mon_e.n1));
            chk({mon_e.tag, "/scnt0"},  scnt0,       mon_e.sc0);
            chk({mon_e.tag, "/fcnt0"},  fcnt0,       mon_e.fc0);
            chk({mon_e.tag, "/scnt1"},  32'(scnt1),  32'(mon_e.sc1));
            chk({mon_e.tag, "/fcnt1"},  32'(fcnt1),  32'(mon_e.fc1));
        end
    end

    task automatic clr();
        rst = 1'b1; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        wr_reg = 15'd0; wr_en = 3'b000; wr_is_load = 3'b000; branch_taken = 1'b0;
        iready_n = 1'b0; dready_n = 1'b0; dbusy = 1'b0; mem_rw = 2'b00;
    endtask

    task automatic set_slot(input int k, input logic [4:0] r);
        wr_reg[k*5 +: 5] = r;
    endtask

    // Queue this cycle's expectation, advance the counter model, move to next cycle.
    task automatic step(input string tag, input logic [4:0] s0, input logic [4:0] n0,
                        input logic [4:0] s1, input logic [4:0] n1);
        exp_t e;
        e.tag = tag; e.s0 = s0; e.n0 = n0; e.s1 = s1; e.n1 = n1;
        e.sc0 = m_sc0; e.fc0 = m_fc0; e.sc1 = m_sc1; e.fc1 = m_fc1;
        sb.push_back(e);
        if (!rst) begin
            m_sc0 = 32'd0; m_fc0 = 32'd0; m_sc1 = 4'd0; m_fc1 = 4'd0;
        end else begin
            if (s0[0]) m_sc0 = m_sc0 + 32'd1;
            if (n0[1]) m_fc0 = m_fc0 + 32'd1;
            if (s1[0] && (m_sc1 != 4'hF)) m_sc1 = m_sc1 + 4'd1;
            if (n1[1] && (m_fc1 != 4'hF)) m_fc1 = m_fc1 + 4'd1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr();
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Outputs forced low under reset even with a busy memory.
        clr(); rst = 1'b0; dbusy = 1'b1;             step("rst_busy", Z, Z, Z, Z);
        clr();                                        step("idle", Z, Z, Z, Z);

        // RAW detection against older writers.
        clr(); id_rs1 = 5'd5; id_rs1_used = 1'b1; set_slot(1, 5'd5); wr_en = 3'b010;
        step("raw_rs1_slot1", RS, RN, Z, Z);
        clr(); id_rs2 = 5'd5; id_rs2_used = 1'b1; set_slot(2, 5'd5); wr_en = 3'b100;
        step("raw_rs2_slot2", RS, RN, Z, Z);
        clr(); id_rs1 = 5'd5; id_rs1_used = 1'b1; set_slot(1, 5'd5); wr_en = 3'b000;
        step("no_wren", Z, Z, Z, Z);
        clr(); id_rs1 = 5'd5; id_rs1_used = 1'b0; set_slot(1, 5'd5); wr_en = 3'b010;
        step("rs1_unused", Z, Z, Z, Z);

        // Forwarding variant: only a load in EX stalls.
        clr(); id_rs1 = 5'd5; id_rs1_used = 1'b1; set_slot(0, 5'd5); wr_en = 3'b001;
        step("ex_alu", RS, RN, Z, Z);
        wr_is_load = 3'b001;                          step("ex_load", RS, RN, RS, RN);
        clr(); id_rs1 = 5'd5; id_rs1_used = 1'b1; set_slot(1, 5'd5); wr_en = 3'b010; wr_is_load = 3'b010;
        step("mem_load_fwd", RS, RN, Z, Z);
        clr(); id_rs1 = 5'd0; id_rs1_used = 1'b1; set_slot(0, 5'd0); wr_en = 3'b111; wr_is_load = 3'b111;
        step("x0", Z, Z, Z, Z);

        // External memory waits.
        clr(); dready_n = 1'b1; mem_rw = 2'b10;      step("dready_rd", ALL, Z, ALL, Z);
        clr(); dready_n = 1'b1;                       step("dready_norm", Z, Z, Z, Z);
        clr(); iready_n = 1'b1;                       step("iready", ALL, Z, ALL, Z);

        // Lone store: two held cycles, then it leaves MEM.
        clr(); mem_rw = 2'b01;
        step("st_h1", ALL, Z, ALL, Z);
        step("st_h2", ALL, Z, ALL, Z);
        step("st_go", Z, Z, Z, Z);
        clr();                                        step("st_after", Z, Z, Z, Z);
        // Back-to-back stores.
        clr(); mem_rw = 2'b01;
        for (int i = 0; i < 2; i++) begin
            step("b2b_h1", ALL, Z, ALL, Z);
            step("b2b_h2", ALL, Z, ALL, Z);
            step("b2b_go", Z, Z, Z, Z);
        end
        clr();                                        step("b2b_after", Z, Z, Z, Z);

        // Branch during a memory stall is deferred to the first free cycle.
        clr(); branch_taken = 1'b1; dbusy = 1'b1;    step("br_busy1", ALL, Z, ALL, Z);
        clr(); dbusy = 1'b1;                          step("br_busy2", ALL, Z, ALL, Z);
        clr(); dbusy = 1'b1;                          step("br_busy3", ALL, Z, ALL, Z);
        clr();                                        step("br_apply", Z, FN, Z, FN);
        clr();                                        step("br_after", Z, Z, Z, Z);

        // Flush overrides a RAW hazard.
        clr(); id_rs1 = 5'd5; id_rs1_used = 1'b1; set_slot(0, 5'd5); wr_en = 3'b001; wr_is_load = 3'b001;
        branch_taken = 1'b1;                          step("br_raw", Z, FN, Z, FN);

        // Reset in the middle of a store hold returns the FSM to idle.
        clr(); mem_rw = 2'b01;                        step("hold_pre", ALL, Z, ALL, Z);
        clr(); rst = 1'b0; mem_rw = 2'b01;            step("hold_rst", Z, Z, Z, Z);
        clr();                                        step("hold_post", Z, Z, Z, Z);

        // Counter saturation on the 4-bit instance.
        clr(); iready_n = 1'b1;
        for (int i = 0; i < 20; i++) step("sat_stall", ALL, Z, ALL, Z);
        clr(); branch_taken = 1'b1;
        for (int i = 0; i < 18; i++) step("sat_flush", Z, FN, Z, FN);
        clr();                                        step("final", Z, Z, Z, Z);

        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
